// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the pipelined MIPS core.
//   - fetch_state_e : instruction-fetch FSM states
//   - NOP_INSTR     : bubble instruction (sll $0,$0,0)
//   - PC_STEP       : byte distance between sequential instructions
//   - OP_*          : opcode field values (instruction[31:26]) used by the Decoder
package cpu_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,  // request at pc_q, accept data on ready
    DRAIN = 1'b1   // redirected mid-miss: wait out the old request, discard it
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: pipeline register between two stages (IF/ID here; the same
// shape serves ID/EX). Flush inserts a bubble, load captures new contents,
// otherwise the register holds. Flush wins over load.
// Ports:
//   clk_i, rst_i        clock, async active-low reset
//   load_i, flush_i     capture / bubble controls
//   instr_i, pc4_i      incoming instruction and PC+4
//   instr_o, pc4_o      registered instruction and PC+4
//   valid_o             register holds a real instruction
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] pc4_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic              valid_o
);

  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc4;
  logic              r_valid;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (load_i) begin
      r_instr <= instr_i;
      r_pc4   <= pc4_i;
      r_valid <= 1'b1;
    end
  end

  assign instr_o = r_instr;
  assign pc4_o   = r_pc4;
  assign valid_o = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the pipelined MIPS core. Owns the PC,
// issues requests to a variable-latency I-cache and fills IF/ID.
// Ports:
//   clk_i, rst_i                 clock, async active-low reset
//   imem_req_o, imem_addr_o      I-cache request / word-aligned address
//   imem_data_i, imem_ready_i    I-cache response (ready completes request)
//   stall_i                      hazard-unit hold of PC and IF/ID
//   redirect_i, redirect_pc_i    taken branch/jump and its target
//   if_id_instr_o/pc4_o/valid_o  IF/ID contents
//   fetch_busy_o                 waiting on memory
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_data_i,
  input  logic              imem_ready_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [31:0]       if_id_instr_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic              if_id_valid_o,
  output logic              fetch_busy_o
);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pend_pc, w_pend_nxt;
  logic [ADDR_W-1:0] w_pc4, w_redir_pc;
  logic              w_load, w_flush;

  // Wraps naturally at 2^ADDR_W.
  assign w_pc4      = r_pc + ADDR_W'(PC_STEP);
  // Targets are forced word aligned.
  assign w_redir_pc = redirect_pc_i & ~ADDR_W'(3);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= FETCH;
      r_pc      <= PC_RESET;
      r_pend_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_pc;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      DRAIN: begin
        // The in-flight request cannot be aborted: keep bubbling until it
        // returns, then drop its data and jump to the latest target.
        w_flush = ~stall_i;
        if (imem_ready_i) begin
          w_pc_nxt    = redirect_i ? w_redir_pc : r_pend_pc;
          w_state_nxt = FETCH;
        end else if (redirect_i) begin
          w_pend_nxt = w_redir_pc;
        end
      end
      default: begin
        if (redirect_i) begin
          w_flush = 1'b1;
          if (imem_ready_i) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_pend_nxt  = w_redir_pc;
            w_state_nxt = DRAIN;
          end
        end else if (stall_i) begin
          // Hold; returned data is dropped and the same PC is refetched.
        end else if (imem_ready_i) begin
          w_load   = 1'b1;
          w_pc_nxt = w_pc4;
        end else begin
          // Miss: bubble so a stale instruction is never decoded twice.
          w_flush = 1'b1;
        end
      end
    endcase
  end

  assign imem_req_o   = rst_i;
  assign imem_addr_o  = r_pc;
  assign fetch_busy_o = (r_state == DRAIN) | ((r_state == FETCH) & ~imem_ready_i);

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_load),
    .flush_i (w_flush),
    .instr_i (imem_data_i),
    .pc4_i   (w_pc4),
    .instr_o (if_id_instr_o),
    .pc4_o   (if_id_pc4_o),
    .valid_o (if_id_valid_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        imem_ready_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic        fetch_busy_o;

  logic        auto_data;
  logic [31:0] man_data;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk_i = ~clk_i;

  // Memory model: hits return addr|0x1000 unless a vector forces data.
  assign imem_data_i = auto_data ? (imem_addr_o | 32'h1000) : man_data;

  fetch_stage #(.ADDR_W(32), .PC_RESET(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .imem_ready_i  (imem_ready_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_valid_o (if_id_valid_o),
    .fetch_busy_o  (fetch_busy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; imem_ready_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; auto_data = 1'b1; man_data = '0;
    #2;
    nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL reset_req got %b exp 0", imem_req_o); end
    nvec++; if (imem_addr_o !== 32'h0) begin nerr++; $display("FAIL reset_addr got %h exp 0", imem_addr_o); end
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== 65'h0)
      begin nerr++; $display("FAIL reset_ifid got %h/%h/%b exp 0/0/0", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    tick();
    rst_i = 1'b1;
    #1;
    nvec++; if (imem_req_o !== 1'b1) begin nerr++; $display("FAIL post_reset_req got %b exp 1", imem_req_o); end
  endtask

  // Back-to-back hits from PC 0, then a 3-cycle miss at PC 8.
  task automatic test_hits_and_miss();
    imem_ready_i = 1'b1;
    #1;
    nvec++; if (fetch_busy_o !== 1'b0) begin nerr++; $display("FAIL hit_busy got %b exp 0", fetch_busy_o); end
    tick();
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h1000, 32'h4, 1'b1})
      begin nerr++; $display("FAIL hit0_ifid got %h/%h/%b exp 1000/4/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    nvec++; if (imem_addr_o !== 32'h4) begin nerr++; $display("FAIL hit0_addr got %h exp 4", imem_addr_o); end
    tick();
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h1004, 32'h8, 1'b1})
      begin nerr++; $display("FAIL hit1_ifid got %h/%h/%b exp 1004/8/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    nvec++; if (imem_addr_o !== 32'h8) begin nerr++; $display("FAIL hit1_addr got %h exp 8", imem_addr_o); end
    imem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (fetch_busy_o !== 1'b1) begin nerr++; $display("FAIL miss_busy[%0d] got %b exp 1", i, fetch_busy_o); end
      tick();
      nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== 65'h0)
        begin nerr++; $display("FAIL miss_bubble[%0d] got %h/%h/%b exp 0/0/0", i, if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
      nvec++; if (imem_addr_o !== 32'h8) begin nerr++; $display("FAIL miss_addr[%0d] got %h exp 8", i, imem_addr_o); end
    end
    imem_ready_i = 1'b1; auto_data = 1'b0; man_data = 32'h2002_0005;
    #1;
    nvec++; if (fetch_busy_o !== 1'b0) begin nerr++; $display("FAIL miss_done_busy got %b exp 0", fetch_busy_o); end
    tick();
    auto_data = 1'b1;
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h2002_0005, 32'hC, 1'b1})
      begin nerr++; $display("FAIL miss_fill got %h/%h/%b exp 20020005/c/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    tick();
    nvec++; if (imem_addr_o !== 32'h10) begin nerr++; $display("FAIL miss_next_addr got %h exp 10", imem_addr_o); end
  endtask

  // Two stall cycles at PC 0x10 with ready high.
  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h100C, 32'h10, 1'b1})
        begin nerr++; $display("FAIL stall_hold[%0d] got %h/%h/%b exp 100c/10/1", i, if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
      nvec++; if (imem_addr_o !== 32'h10) begin nerr++; $display("FAIL stall_addr[%0d] got %h exp 10", i, imem_addr_o); end
    end
    stall_i = 1'b0;
    tick();
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h1010, 32'h14, 1'b1})
      begin nerr++; $display("FAIL stall_refetch got %h/%h/%b exp 1010/14/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    nvec++; if (imem_addr_o !== 32'h14) begin nerr++; $display("FAIL stall_next_addr got %h exp 14", imem_addr_o); end
  endtask

  // Redirect to unaligned 0x43 during a hit at 0x20.
  task automatic test_redirect_hit();
    tick(); tick(); tick();
    nvec++; if (imem_addr_o !== 32'h20) begin nerr++; $display("FAIL pre_redir_addr got %h exp 20", imem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h43;
    tick();
    redirect_i = 1'b0;
    nvec++; if (imem_addr_o !== 32'h40) begin nerr++; $display("FAIL redir_addr got %h exp 40", imem_addr_o); end
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== 65'h0)
      begin nerr++; $display("FAIL redir_bubble got %h/%h/%b exp 0/0/0", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    tick();
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h1040, 32'h44, 1'b1})
      begin nerr++; $display("FAIL redir_fill got %h/%h/%b exp 1040/44/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
  endtask

  // Miss at 0x30, redirect to 0x100, then 0x200 two cycles later, then ready.
  task automatic test_redirect_miss();
    redirect_i = 1'b1; redirect_pc_i = 32'h30;
    tick();
    redirect_i = 1'b0; imem_ready_i = 1'b0;
    tick();
    nvec++; if (imem_addr_o !== 32'h30) begin nerr++; $display("FAIL miss30_addr got %h exp 30", imem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    #1;
    nvec++; if (fetch_busy_o !== 1'b1) begin nerr++; $display("FAIL drain_busy got %b exp 1", fetch_busy_o); end
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    nvec++; if (imem_addr_o !== 32'h30) begin nerr++; $display("FAIL drain_addr got %h exp 30", imem_addr_o); end
    nvec++; if (if_id_valid_o !== 1'b0) begin nerr++; $display("FAIL drain_valid got %b exp 0", if_id_valid_o); end
    tick();
    imem_ready_i = 1'b1; auto_data = 1'b0; man_data = 32'hDEAD_BEEF;
    #1;
    nvec++; if (fetch_busy_o !== 1'b1) begin nerr++; $display("FAIL drain_ready_busy got %b exp 1", fetch_busy_o); end
    tick();
    auto_data = 1'b1;
    nvec++; if (imem_addr_o !== 32'h200) begin nerr++; $display("FAIL drain_exit_addr got %h exp 200", imem_addr_o); end
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== 65'h0)
      begin nerr++; $display("FAIL drain_discard got %h/%h/%b exp 0/0/0", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    tick();
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h1200, 32'h204, 1'b1})
      begin nerr++; $display("FAIL drain_fill got %h/%h/%b exp 1200/204/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
  endtask

  // Reset asserted while draining; a late ready completes the PC_RESET fetch.
  task automatic test_reset_mid_miss();
    imem_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    rst_i = 1'b0;
    #1;
    nvec++; if (imem_addr_o !== 32'h0) begin nerr++; $display("FAIL rst_mid_addr got %h exp 0", imem_addr_o); end
    nvec++; if (imem_req_o !== 1'b0) begin nerr++; $display("FAIL rst_mid_req got %b exp 0", imem_req_o); end
    tick();
    rst_i = 1'b1; imem_ready_i = 1'b1;
    #1;
    nvec++; if (fetch_busy_o !== 1'b0) begin nerr++; $display("FAIL rst_mid_state_busy got %b exp 0", fetch_busy_o); end
    nvec++; if (if_id_valid_o !== 1'b0) begin nerr++; $display("FAIL rst_mid_valid got %b exp 0", if_id_valid_o); end
    tick();
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'h1000, 32'h4, 1'b1})
      begin nerr++; $display("FAIL rst_mid_fill got %h/%h/%b exp 1000/4/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
  endtask

  // PC 0xFFFF_FFFC hit wraps to 0.
  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0;
    nvec++; if (imem_addr_o !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr_o); end
    tick();
    nvec++; if ({if_id_instr_o, if_id_pc4_o, if_id_valid_o} !== {32'hFFFF_FFFC, 32'h0, 1'b1})
      begin nerr++; $display("FAIL wrap_ifid got %h/%h/%b exp fffffffc/0/1", if_id_instr_o, if_id_pc4_o, if_id_valid_o); end
    nvec++; if (imem_addr_o !== 32'h0) begin nerr++; $display("FAIL wrap_next_addr got %h exp 0", imem_addr_o); end
  endtask

  initial begin
    test_reset();
    test_hits_and_miss();
    test_stall();
    test_redirect_hit();
    test_redirect_miss();
    test_reset_mid_miss();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
